// File: rtl/control_unit.sv
// Multi-cycle main control FSM for the RV32I core.
// Decodes the IR fields into datapath enables, mux selects and the ALU
// operation code, resolves branches from the ALU zero flag, and sequences
// instruction/data memory accesses through a ready handshake.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] CU_OPCODE_i,
    input  logic [2:0] CU_FUNCT3_i,
    input  logic       CU_FUNCT7B5_i,
    input  logic       CU_ZR_i,
    input  logic       CU_MEM_RDY_i,
    output logic       CU_PC_WR_o,
    output logic       CU_IR_WR_o,
    output logic       CU_MEM_RD_o,
    output logic       CU_MEM_WR_o,
    output logic       CU_ADDR_SEL_o,
    output logic       CU_REG_WR_o,
    output logic [1:0] CU_SRC_A_o,
    output logic [1:0] CU_SRC_B_o,
    output logic       CU_PC_SRC_o,
    output logic       CU_WB_SEL_o,
    output logic [3:0] CU_ALU_OP_o,
    output logic       CU_TRAP_o
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_BRANCH, S_JALR_ADDR,
        S_JUMP, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b1010;
    localparam logic [3:0] ALU_GE   = 4'b1100;
    localparam logic [3:0] ALU_GEU  = 4'b1101;
    localparam logic [3:0] ALU_SLT  = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1111;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;

    localparam logic [1:0] SA_PC    = 2'b00;
    localparam logic [1:0] SA_OLDPC = 2'b01;
    localparam logic [1:0] SA_RS1   = 2'b10;
    localparam logic [1:0] SA_ZERO  = 2'b11;
    localparam logic [1:0] SB_RS2   = 2'b00;
    localparam logic [1:0] SB_IMM   = 2'b01;
    localparam logic [1:0] SB_FOUR  = 2'b10;

    state_t     state_reg;
    state_t     state_next;

    logic       pc_wr;
    logic       ir_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       reg_wr;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       pc_src;
    logic       wb_sel;
    logic [3:0] alu_op;
    logic       trap;

    // Arithmetic op for R/I-type; SUB only exists for register-register adds.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic b5,
                                            input logic is_r);
        case (f3)
            3'b000:  arith_op = (is_r && b5) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = b5 ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // State register; async reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and state-decoded datapath controls.
    always_comb begin
        state_next = state_reg;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr_sel   = 1'b0;
        reg_wr     = 1'b0;
        src_a      = SA_PC;
        src_b      = SB_RS2;
        pc_src     = 1'b0;
        wb_sel     = 1'b0;
        alu_op     = ALU_ADD;
        trap       = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_rd = 1'b1;
                src_b  = SB_FOUR;
                ir_wr  = CU_MEM_RDY_i;
                pc_wr  = CU_MEM_RDY_i;
                if (CU_MEM_RDY_i) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively form the branch/JAL target into ALUOut.
                src_a = SA_OLDPC;
                src_b = SB_IMM;
                case (CU_OPCODE_i)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_LUI, OP_AUIPC:  state_next = S_EXEC_U;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JUMP;
                    OP_JALR:           state_next = S_JALR_ADDR;
                    OP_FENCE:          state_next = S_FETCH;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                src_a      = SA_RS1;
                src_b      = SB_IMM;
                // Stores differ from loads only in opcode bit 5.
                state_next = CU_OPCODE_i[5] ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_rd   = 1'b1;
                addr_sel = 1'b1;
                if (CU_MEM_RDY_i) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_wr     = 1'b1;
                wb_sel     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_wr   = 1'b1;
                addr_sel = 1'b1;
                if (CU_MEM_RDY_i) state_next = S_FETCH;
            end
            S_EXEC_R: begin
                src_a      = SA_RS1;
                src_b      = SB_RS2;
                alu_op     = arith_op(CU_FUNCT3_i, CU_FUNCT7B5_i, 1'b1);
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a      = SA_RS1;
                src_b      = SB_IMM;
                alu_op     = arith_op(CU_FUNCT3_i, CU_FUNCT7B5_i, 1'b0);
                state_next = S_ALU_WB;
            end
            S_EXEC_U: begin
                src_a      = (CU_OPCODE_i == OP_LUI) ? SA_ZERO : SA_OLDPC;
                src_b      = SB_IMM;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_wr     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                src_a      = SA_RS1;
                src_b      = SB_RS2;
                pc_src     = 1'b1;
                state_next = S_FETCH;
                // The ALU result is zero exactly when BEQ is taken, and is
                // non-zero (compare true / operands differ) for the others.
                pc_wr      = (CU_FUNCT3_i == 3'b000) ? CU_ZR_i : ~CU_ZR_i;
                case (CU_FUNCT3_i)
                    3'b000, 3'b001: alu_op = ALU_SUB;
                    3'b100:         alu_op = ALU_SLT;
                    3'b101:         alu_op = ALU_GE;
                    3'b110:         alu_op = ALU_SLTU;
                    3'b111:         alu_op = ALU_GEU;
                    default: begin
                        pc_wr      = 1'b0;
                        state_next = S_TRAP;
                    end
                endcase
            end
            S_JALR_ADDR: begin
                src_a      = SA_RS1;
                src_b      = SB_IMM;
                state_next = S_JUMP;
            end
            S_JUMP: begin
                // Jump to the target held in ALUOut while computing the link.
                pc_src     = 1'b1;
                pc_wr      = 1'b1;
                src_a      = SA_OLDPC;
                src_b      = SB_FOUR;
                state_next = S_ALU_WB;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // All outputs are held at zero while reset is asserted.
    always_comb begin
        CU_PC_WR_o    = pc_wr    & ~rst;
        CU_IR_WR_o    = ir_wr    & ~rst;
        CU_MEM_RD_o   = mem_rd   & ~rst;
        CU_MEM_WR_o   = mem_wr   & ~rst;
        CU_ADDR_SEL_o = addr_sel & ~rst;
        CU_REG_WR_o   = reg_wr   & ~rst;
        CU_SRC_A_o    = rst ? 2'b00 : src_a;
        CU_SRC_B_o    = rst ? 2'b00 : src_b;
        CU_PC_SRC_o   = pc_src   & ~rst;
        CU_WB_SEL_o   = wb_sel   & ~rst;
        CU_ALU_OP_o   = rst ? 4'b0000 : alu_op;
        CU_TRAP_o     = trap     & ~rst;
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed instructions from the
// test plan followed by randomized instructions and memory wait states,
// each compared against per-instruction totals derived from the ISA rules.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zr;
    logic       mem_rdy;
    logic       pc_wr, ir_wr, mem_rd, mem_wr, addr_sel, reg_wr;
    logic [1:0] src_a, src_b;
    logic       pc_src, wb_sel, trap;
    logic [3:0] alu_op;
    logic [16:0] out_vec;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum int {K_LOAD, K_STORE, K_R, K_I, K_LUI, K_AUIPC, K_BR, K_BR_BAD,
                      K_JAL, K_JALR, K_FENCE, K_BAD} kind_t;

    logic [3:0] r_tab  [8];
    logic [3:0] br_tab [8];
    logic [6:0] op_pool [13];

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .CU_OPCODE_i   (opcode),
        .CU_FUNCT3_i   (funct3),
        .CU_FUNCT7B5_i (funct7b5),
        .CU_ZR_i       (zr),
        .CU_MEM_RDY_i  (mem_rdy),
        .CU_PC_WR_o    (pc_wr),
        .CU_IR_WR_o    (ir_wr),
        .CU_MEM_RD_o   (mem_rd),
        .CU_MEM_WR_o   (mem_wr),
        .CU_ADDR_SEL_o (addr_sel),
        .CU_REG_WR_o   (reg_wr),
        .CU_SRC_A_o    (src_a),
        .CU_SRC_B_o    (src_b),
        .CU_PC_SRC_o   (pc_src),
        .CU_WB_SEL_o   (wb_sel),
        .CU_ALU_OP_o   (alu_op),
        .CU_TRAP_o     (trap)
    );

    assign out_vec = {pc_wr, ir_wr, mem_rd, mem_wr, addr_sel, reg_wr, src_a, src_b,
                      pc_src, wb_sel, alu_op, trap};

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic kind_t classify(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? K_BR_BAD : K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0001111: return K_FENCE;
            default:    return K_BAD;
        endcase
    endfunction

    // ALU op expected in the cycle that reads rs1.
    function automatic logic [3:0] exp_alu(input kind_t k, input logic [2:0] f3,
                                           input logic b5);
        logic [3:0] v;
        v = 4'b0010;
        if (k == K_R || k == K_I) begin
            v = r_tab[f3];
            if (f3 == 3'b000 && k == K_R && b5) v = 4'b1010;
            if (f3 == 3'b101 && b5) v = 4'b0111;
        end else if (k == K_BR) begin
            v = br_tab[f3];
        end
        return v;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_value("rst_outs_zero", 32'(out_vec), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Runs one instruction starting in its FETCH cycle (positioned just after
    // a falling edge), returning in the next FETCH cycle, or after 10 TRAP
    // cycles (in which case the FSM is reset afterwards).
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic b5, input logic z, input int w);
        kind_t k;
        int cycles, n_regwr, n_wbmem, n_pcwr, n_irwr, n_drd, n_dwr;
        int n_zero, n_trap, n_trap_en, wcnt;
        int e_cyc, e_pcwr, fetch;
        logic [3:0] rs1_op;
        bit phase, done, is_fetch, taken, is_wb;
        k = classify(op, f3);
        cycles = 0; n_regwr = 0; n_wbmem = 0; n_pcwr = 0; n_irwr = 0; n_drd = 0;
        n_dwr = 0; n_zero = 0; n_trap = 0; n_trap_en = 0; wcnt = 0;
        rs1_op = 4'b1001;
        phase = 1'b0; done = 1'b0;
        opcode = op; funct3 = f3; funct7b5 = b5; zr = z;
        for (int c = 0; c < 200 && !done; c++) begin
            is_fetch = mem_rd && !addr_sel;
            if (phase && is_fetch) begin
                done = 1'b1;
            end else begin
                if (mem_rd || mem_wr) begin
                    if (wcnt == w) begin
                        mem_rdy = 1'b1;
                        wcnt = 0;
                    end else begin
                        mem_rdy = 1'b0;
                        wcnt++;
                    end
                end else begin
                    mem_rdy = 1'($urandom_range(0, 1));
                end
                #1;
                cycles++;
                if (!is_fetch) phase = 1'b1;
                if (reg_wr) n_regwr++;
                if (reg_wr && wb_sel) n_wbmem++;
                if (pc_wr) n_pcwr++;
                if (ir_wr) n_irwr++;
                if (mem_rd && addr_sel) n_drd++;
                if (mem_wr) n_dwr++;
                if (src_a == 2'b11) n_zero++;
                if (src_a == 2'b10) rs1_op = alu_op;
                if (trap) begin
                    n_trap++;
                    if (pc_wr || ir_wr || mem_rd || mem_wr || reg_wr) n_trap_en++;
                    if (n_trap == 10) done = 1'b1;
                end
                if (!done) begin
                    @(negedge clk);
                    #1;
                end
            end
        end
        check_value("instr_done", 32'(done), 32'd1);

        fetch = 1 + w;
        taken = (f3 == 3'b000) ? z : !z;
        case (k)
            K_LOAD:   e_cyc = fetch + 3 + (1 + w);
            K_STORE:  e_cyc = fetch + 2 + (1 + w);
            K_BR:     e_cyc = fetch + 2;
            K_JALR:   e_cyc = fetch + 4;
            K_FENCE:  e_cyc = fetch + 1;
            K_BAD:    e_cyc = fetch + 1 + 10;
            K_BR_BAD: e_cyc = fetch + 2 + 10;
            default:  e_cyc = fetch + 3;
        endcase
        e_pcwr = 1;
        if (k == K_JAL || k == K_JALR) e_pcwr++;
        if (k == K_BR && taken) e_pcwr++;
        is_wb = (k == K_LOAD || k == K_R || k == K_I || k == K_LUI || k == K_AUIPC ||
                 k == K_JAL || k == K_JALR);

        check_value("cycles", 32'(cycles), 32'(e_cyc));
        check_value("reg_wr_count", 32'(n_regwr), is_wb ? 32'd1 : 32'd0);
        check_value("wb_mem_count", 32'(n_wbmem), (k == K_LOAD) ? 32'd1 : 32'd0);
        check_value("pc_wr_count", 32'(n_pcwr), 32'(e_pcwr));
        check_value("ir_wr_count", 32'(n_irwr), 32'd1);
        check_value("data_rd_cycles", 32'(n_drd), (k == K_LOAD) ? 32'(1 + w) : 32'd0);
        check_value("data_wr_cycles", 32'(n_dwr), (k == K_STORE) ? 32'(1 + w) : 32'd0);
        check_value("src_a_zero", 32'(n_zero), (k == K_LUI) ? 32'd1 : 32'd0);
        check_value("trap_cycles", 32'(n_trap),
                    (k == K_BAD || k == K_BR_BAD) ? 32'd10 : 32'd0);
        check_value("trap_enables", 32'(n_trap_en), 32'd0);
        if (k == K_LOAD || k == K_STORE || k == K_R || k == K_I || k == K_BR ||
            k == K_JALR)
            check_value("alu_op", 32'(rs1_op), 32'(exp_alu(k, f3, b5)));
        $display("instr op=%b f3=%b b5=%0d zr=%0d wait=%0d cycles=%0d", op, f3, b5, z,
                 w, cycles);
        if (n_trap > 0 || !done) apply_reset();
    endtask

    initial begin
        logic [6:0] op;
        r_tab   = '{4'b0010, 4'b0100, 4'b1110, 4'b1111, 4'b1000, 4'b0101, 4'b0001, 4'b0000};
        br_tab  = '{4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b1110, 4'b1100, 4'b1111, 4'b1101};
        op_pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b0110111,
                    7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111,
                    7'b1110011, 7'b0110011, 7'b0010011};

        rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zr = 1'b0;
        mem_rdy = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_value("reset_outs", 32'(out_vec), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("first_fetch", 32'({mem_rd, addr_sel, src_b, alu_op}),
                    32'({1'b1, 1'b0, 2'b10, 4'b0010}));

        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0);   // SUB
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3);   // LW, 3 wait cycles
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0);   // BEQ taken
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, 0);   // BNE not taken
        run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 0);   // BGE taken
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, 0);   // SRAI
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0);   // ADDI with b5 set
        run_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 0);   // JALR
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1);   // SW
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0);   // JAL
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 0);   // LUI
        run_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 0);   // AUIPC
        run_instr(7'b0001111, 3'b000, 1'b0, 1'b0, 0);   // FENCE
        run_instr(7'b1100011, 3'b010, 1'b0, 1'b0, 0);   // illegal branch
        run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0);   // SYSTEM -> trap

        // Reset asserted while a store is waiting on memory.
        opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int c = 0; c < 10 && !found; c++) begin
                if (mem_wr) begin
                    found = 1'b1;
                end else begin
                    mem_rdy = 1'b1;
                    @(negedge clk);
                    #1;
                end
            end
            check_value("reach_mem_write", 32'(found), 32'd1);
            mem_rdy = 1'b0;
            #1;
            rst = 1'b1;
            #1;
            check_value("rst_drops_mem_wr", 32'(mem_wr), 32'd0);
            check_value("rst_mid_outs", 32'(out_vec), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            #1;
            check_value("fetch_after_rst", 32'({mem_rd, mem_wr, addr_sel, src_b}),
                        32'({1'b1, 1'b0, 1'b0, 2'b10}));
        end

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else op = op_pool[$urandom_range(0, 12)];
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
